// File: rtl/mem_access_ctrl.sv
// Memory-access stage: retires ALU results to writeback, runs loads/stores over a
// req/ack data-memory handshake with timeout, and counts completed memory ops.
module mem_access_ctrl #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned RD_W    = 5,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        load,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [RD_W-1:0]   rd,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [RD_W-1:0]   wb_rd,
  output logic              err_align,
  output logic              err_timeout,
  output logic [CNT_W-1:0]  load_cnt,
  output logic [CNT_W-1:0]  store_cnt
);

  // Counter only needs to reach TIMEOUT-1: that is the last MEM cycle before abort.
  localparam int unsigned TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] LD_NOP   = 2'b00;
  localparam logic [1:0] LD_ALU   = 2'b01;
  localparam logic [1:0] LD_STORE = 2'b10;
  localparam logic [1:0] LD_LOAD  = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MEM  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [RD_W-1:0]     rd_q, rd_d;
  logic                wb_valid_q, wb_valid_d;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;
  logic [RD_W-1:0]     wb_rd_q, wb_rd_d;
  logic                err_align_q, err_align_d;
  logic                err_timeout_q, err_timeout_d;
  logic [CNT_W-1:0]    load_cnt_q, load_cnt_d;
  logic [CNT_W-1:0]    store_cnt_q, store_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      to_cnt_q      <= '0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      rd_q          <= '0;
      wb_valid_q    <= 1'b0;
      wb_data_q     <= '0;
      wb_rd_q       <= '0;
      err_align_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      load_cnt_q    <= '0;
      store_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      to_cnt_q      <= to_cnt_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      rd_q          <= rd_d;
      wb_valid_q    <= wb_valid_d;
      wb_data_q     <= wb_data_d;
      wb_rd_q       <= wb_rd_d;
      err_align_q   <= err_align_d;
      err_timeout_q <= err_timeout_d;
      load_cnt_q    <= load_cnt_d;
      store_cnt_q   <= store_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    to_cnt_d      = to_cnt_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    rd_d          = rd_q;
    wb_valid_d    = 1'b0;
    wb_data_d     = wb_data_q;
    wb_rd_d       = wb_rd_q;
    err_align_d   = 1'b0;
    err_timeout_d = err_timeout_q;
    load_cnt_d    = load_cnt_q;
    store_cnt_d   = store_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          case (load)
            LD_ALU: begin
              wb_valid_d = 1'b1;
              wb_data_d  = DATA_W'(addr);
              wb_rd_d    = rd;
            end
            LD_LOAD, LD_STORE: begin
              if (addr[1:0] != 2'b00) begin
                err_align_d = 1'b1;
              end else begin
                state_d     = ST_MEM;
                to_cnt_d    = '0;
                mem_req_d   = 1'b1;
                mem_we_d    = (load == LD_STORE);
                mem_addr_d  = addr;
                mem_wdata_d = wdata;
                rd_d        = rd;
              end
            end
            default: ;
          endcase
        end
      end
      ST_MEM: begin
        // An ack arriving on the final allowed cycle still completes normally.
        if (mem_ack) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          if (!mem_we_q) begin
            wb_valid_d = 1'b1;
            wb_data_d  = mem_rdata;
            wb_rd_d    = rd_q;
            load_cnt_d = load_cnt_q + CNT_W'(1);
          end else begin
            store_cnt_d = store_cnt_q + CNT_W'(1);
          end
        end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          state_d       = ST_IDLE;
          mem_req_d     = 1'b0;
          err_timeout_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign wb_valid    = wb_valid_q;
  assign wb_data     = wb_data_q;
  assign wb_rd       = wb_rd_q;
  assign err_align   = err_align_q;
  assign err_timeout = err_timeout_q;
  assign load_cnt    = load_cnt_q;
  assign store_cnt   = store_cnt_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed cases followed by random
// transactions, expectations computed per transaction from the stage's rules.
module tb_mem_access_ctrl;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned RW = 5;
  localparam int unsigned TO = 16;
  localparam int unsigned CW = 16;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    load;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [RW-1:0] rd;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          wb_valid;
  logic [DW-1:0] wb_data;
  logic [RW-1:0] wb_rd;
  logic          err_align;
  logic          err_timeout;
  logic [CW-1:0] load_cnt;
  logic [CW-1:0] store_cnt;

  mem_access_ctrl #(
    .DATA_W(DW), .ADDR_W(AW), .RD_W(RW), .TIMEOUT(TO), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .load(load), .addr(addr), .wdata(wdata), .rd(rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
    .err_align(err_align), .err_timeout(err_timeout),
    .load_cnt(load_cnt), .store_cnt(store_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: only the architecturally visible totals.
  logic [CW-1:0] exp_lc;
  logic [CW-1:0] exp_sc;
  logic          exp_to;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_totals(input string tag);
    chk({tag, "_load_cnt"}, 64'(load_cnt), 64'(exp_lc));
    chk({tag, "_store_cnt"}, 64'(store_cnt), 64'(exp_sc));
    chk({tag, "_err_timeout"}, 64'(err_timeout), 64'(exp_to));
  endtask

  // One ALU op; the stage is expected to retire it on the next edge.
  task automatic alu_op(input logic [AW-1:0] a, input logic [RW-1:0] r, input logic noise_ack);
    chk("alu_in_ready", 64'(in_ready), 64'(1));
    in_valid  = 1'b1;
    load      = 2'b01;
    addr      = a;
    rd        = r;
    mem_ack   = noise_ack;
    mem_rdata = $urandom;
    step();
    chk("alu_wb_valid", 64'(wb_valid), 64'(1));
    chk("alu_wb_data", 64'(wb_data), 64'(a));
    chk("alu_wb_rd", 64'(wb_rd), 64'(r));
    chk("alu_mem_req", 64'(mem_req), 64'(0));
  endtask

  task automatic quiesce();
    in_valid = 1'b0;
    load     = 2'b00;
    mem_ack  = 1'b0;
    step();
    chk("quiet_wb_valid", 64'(wb_valid), 64'(0));
    chk("quiet_err_align", 64'(err_align), 64'(0));
    chk("quiet_mem_req", 64'(mem_req), 64'(0));
    chk_totals("quiet");
  endtask

  task automatic nop_op();
    in_valid = 1'b1;
    load     = 2'b00;
    addr     = $urandom;
    step();
    in_valid = 1'b0;
    chk("nop_wb_valid", 64'(wb_valid), 64'(0));
    chk("nop_err_align", 64'(err_align), 64'(0));
    chk("nop_mem_req", 64'(mem_req), 64'(0));
    chk("nop_in_ready", 64'(in_ready), 64'(1));
  endtask

  task automatic misalign_op(input logic [1:0] op, input logic [AW-1:0] a);
    chk("mis_in_ready", 64'(in_ready), 64'(1));
    in_valid = 1'b1;
    load     = op;
    addr     = a;
    step();
    in_valid = 1'b0;
    load     = 2'b00;
    chk("mis_err_align", 64'(err_align), 64'(1));
    chk("mis_mem_req", 64'(mem_req), 64'(0));
    chk("mis_wb_valid", 64'(wb_valid), 64'(0));
    chk("mis_in_ready_after", 64'(in_ready), 64'(1));
    step();
    chk("mis_err_align_pulse", 64'(err_align), 64'(0));
    chk_totals("mis");
  endtask

  // Aligned load/store; ack is raised in the d-th cycle of mem_req (0 = first),
  // so the request stays up min(d, TO-1)+1 cycles and times out when d >= TO.
  task automatic mem_op(input bit is_store, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input logic [RW-1:0] r, input int d, input logic [DW-1:0] rdat);
    int  exp_high;
    bit  completes;
    completes = (d < int'(TO));
    exp_high  = completes ? d + 1 : int'(TO);
    chk("mem_in_ready", 64'(in_ready), 64'(1));
    in_valid  = 1'b1;
    load      = is_store ? 2'b10 : 2'b11;
    addr      = a;
    wdata     = wd;
    rd        = r;
    mem_ack   = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    step();
    in_valid = 1'b0;
    load     = 2'($urandom);
    addr     = $urandom;
    wdata    = $urandom;
    rd       = RW'($urandom);
    for (int k = 0; k < exp_high; k++) begin
      chk("mem_req_high", 64'(mem_req), 64'(1));
      chk("mem_we", 64'(mem_we), 64'(is_store));
      chk("mem_addr", 64'(mem_addr), 64'(a));
      chk("mem_wdata", 64'(mem_wdata), 64'(wd));
      chk("mem_in_ready_low", 64'(in_ready), 64'(0));
      chk("mem_wb_quiet", 64'(wb_valid), 64'(0));
      mem_ack   = (k == d);
      mem_rdata = (k == d) ? rdat : DW'($urandom);
      step();
    end
    mem_ack = 1'b0;
    load    = 2'b00;
    if (completes) begin
      if (is_store) exp_sc = exp_sc + CW'(1);
      else          exp_lc = exp_lc + CW'(1);
    end else begin
      exp_to = 1'b1;
    end
    chk("mem_req_low", 64'(mem_req), 64'(0));
    chk("mem_in_ready_back", 64'(in_ready), 64'(1));
    chk("mem_wb_valid", 64'(wb_valid), 64'(completes && !is_store));
    if (completes && !is_store) begin
      chk("mem_wb_data", 64'(wb_data), 64'(rdat));
      chk("mem_wb_rd", 64'(wb_rd), 64'(r));
    end
    chk_totals("mem_done");
    step();
    chk("mem_wb_pulse", 64'(wb_valid), 64'(0));
    chk("mem_req_stays_low", 64'(mem_req), 64'(0));
    chk_totals("mem_after");
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    load      = 2'b00;
    addr      = '0;
    wdata     = '0;
    rd        = '0;
    mem_rdata = '0;
    mem_ack   = 1'b0;
    exp_lc    = '0;
    exp_sc    = '0;
    exp_to    = 1'b0;

    #2;
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_mem_req", 64'(mem_req), 64'(0));
    chk("rst_mem_we", 64'(mem_we), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    chk("rst_wb_valid", 64'(wb_valid), 64'(0));
    chk("rst_wb_data", 64'(wb_data), 64'(0));
    chk("rst_wb_rd", 64'(wb_rd), 64'(0));
    chk("rst_err_align", 64'(err_align), 64'(0));
    chk_totals("rst");
    step();
    rst_n = 1'b1;
    step();

    // ALU burst, back-to-back
    alu_op(32'h10, 5'd1, 1'b0);
    alu_op(32'h20, 5'd2, 1'b0);
    alu_op(32'h30, 5'd3, 1'b0);
    quiesce();

    mem_op(1'b0, 32'h100, 32'h0, 5'd7, 3, 32'hDEADBEEF);
    mem_op(1'b1, 32'h204, 32'hA5A5A5A5, 5'd0, 1, 32'h0);
    misalign_op(2'b11, 32'h102);
    misalign_op(2'b10, 32'h207);
    nop_op();
    quiesce();

    // Ack on the final allowed cycle completes; no ack at all times out.
    mem_op(1'b0, 32'h400, 32'h0, 5'd9, int'(TO) - 1, 32'h12345678);
    mem_op(1'b0, 32'h300, 32'h0, 5'd4, int'(TO) + 2, 32'h0);
    alu_op(32'hCAFE, 5'd31, 1'b1);
    quiesce();
    mem_op(1'b1, 32'h500, 32'h0BADF00D, 5'd2, 0, 32'h0);

    for (int i = 0; i < 60; i++) begin
      int unsigned sel;
      logic [AW-1:0] ra;
      sel = $urandom_range(0, 3);
      ra  = $urandom;
      case (sel)
        0: begin
          int unsigned n;
          n = $urandom_range(1, 3);
          for (int j = 0; j < int'(n); j++) alu_op(AW'($urandom), RW'($urandom), 1'($urandom));
          quiesce();
        end
        1: nop_op();
        2: begin
          if (ra[1:0] == 2'b00) ra[0] = 1'b1;
          misalign_op(2'($urandom_range(2, 3)), ra);
        end
        default: begin
          ra[1:0] = 2'b00;
          mem_op(1'($urandom), ra, DW'($urandom), RW'($urandom),
                 int'($urandom_range(0, TO + 3)), DW'($urandom));
        end
      endcase
    end

    // Reset in the middle of an outstanding load
    in_valid = 1'b1;
    load     = 2'b11;
    addr     = 32'h800;
    rd       = 5'd5;
    step();
    in_valid = 1'b0;
    load     = 2'b00;
    step();
    step();
    chk("midop_mem_req", 64'(mem_req), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    exp_lc = '0;
    exp_sc = '0;
    exp_to = 1'b0;
    chk("midrst_mem_req", 64'(mem_req), 64'(0));
    chk("midrst_in_ready", 64'(in_ready), 64'(1));
    chk("midrst_wb_valid", 64'(wb_valid), 64'(0));
    chk_totals("midrst");
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_in_ready", 64'(in_ready), 64'(1));
    chk("post_rst_mem_req", 64'(mem_req), 64'(0));
    alu_op(32'h77, 5'd11, 1'b0);
    quiesce();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
